// File: rtl/program_loader.sv
// Boot-time program loader.
// Decodes a framed byte stream (header, address, length, data, checksum),
// writes the data bytes into program memory and keeps the CPU held in reset
// until a frame completes with a matching checksum.
module program_loader #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       mem_write,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       cpu_hold,
    output logic       busy,
    output logic       load_done,
    output logic       load_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter fires when it already holds TIMEOUT_CYCLES-1 idle cycles
    // and yet another cycle passes without a byte.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    state_t          state_r;
    logic [7:0]      addr_r;
    logic [8:0]      count_r;   // 9 bits so a length byte of 0 can mean 256
    logic [7:0]      csum_r;
    logic [TW-1:0]   timer_r;

    // Running modulo-256 checksum step.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

    // Frame decoder FSM with registered memory-write and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            addr_r     <= 8'd0;
            count_r    <= 9'd0;
            csum_r     <= 8'd0;
            timer_r    <= '0;
            mem_write  <= 1'b0;
            mem_addr   <= 8'd0;
            mem_data   <= 8'd0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            load_done <= 1'b0;
            if (state_r == ST_IDLE) begin
                timer_r <= '0;
                if (rx_valid && (rx_data == HEADER)) begin
                    state_r    <= ST_ADDR;
                    busy       <= 1'b1;
                    cpu_hold   <= 1'b1;
                    load_error <= 1'b0;
                    csum_r     <= 8'd0;
                end else begin
                    state_r <= ST_IDLE;
                end
            end else if (!rx_valid) begin
                // Silence inside a frame: count it, abort once the limit is hit.
                if (timer_r == TIMEOUT_LAST) begin
                    state_r    <= ST_IDLE;
                    busy       <= 1'b0;
                    load_error <= 1'b1;
                    timer_r    <= '0;
                end else begin
                    timer_r <= timer_r + TW'(1);
                end
            end else begin
                // A byte arrived; it always wins over a pending timeout.
                timer_r <= '0;
                case (state_r)
                    ST_ADDR: begin
                        addr_r  <= rx_data;
                        csum_r  <= csum_add(csum_r, rx_data);
                        state_r <= ST_LEN;
                    end
                    ST_LEN: begin
                        count_r <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        csum_r  <= csum_add(csum_r, rx_data);
                        state_r <= ST_DATA;
                    end
                    ST_DATA: begin
                        mem_write <= 1'b1;
                        mem_addr  <= addr_r;
                        mem_data  <= rx_data;
                        addr_r    <= addr_r + 8'd1;
                        csum_r    <= csum_add(csum_r, rx_data);
                        count_r   <= count_r - 9'd1;
                        if (count_r == 9'd1) begin
                            state_r <= ST_CSUM;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_CSUM: begin
                        if (rx_data == csum_r) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_error <= 1'b1;
                            cpu_hold   <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader with a write scoreboard.
module tb_program_loader;

    localparam int TO = 24;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_hold;
    logic       busy;
    logic       load_done;
    logic       load_error;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    logic [15:0] exp_q[$];

    program_loader #(.HEADER(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_write) begin
            check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                check("write_addr_data", {16'd0, mem_addr, mem_data}, {16'd0, exp_q.pop_front()});
            end
        end
        if (load_done) done_cnt++;
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        tick();
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_busy", busy, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_error", load_error, 0);
        reset = 1'b0;
        tick();

        // Non-header bytes in IDLE are ignored.
        send(8'h00);
        send(8'h5A);
        tick();
        check("idle_busy", busy, 0);

        // Normal load.
        push_wr(8'h10, 8'h11); push_wr(8'h11, 8'h22); push_wr(8'h12, 8'h33);
        send(8'hA5);
        check("norm_busy", busy, 1);
        check("norm_hold_before", cpu_hold, 1);
        send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h79);
        check("norm_done", load_done, 1);
        check("norm_hold_after", cpu_hold, 0);
        check("norm_busy_end", busy, 0);
        tick();
        check("norm_done_pulse", load_done, 0);
        check("norm_q_empty", exp_q.size(), 0);

        // Bad checksum (expected 0x55).
        push_wr(8'h10, 8'h44);
        send(8'hA5);
        check("bad_hold_rearm", cpu_hold, 1);
        send(8'h10); send(8'h01); send(8'h44); send(8'h00);
        check("bad_error", load_error, 1);
        check("bad_hold", cpu_hold, 1);
        check("bad_no_done", load_done, 0);
        check("bad_busy", busy, 0);
        tick();
        check("bad_error_sticky", load_error, 1);
        push_wr(8'h10, 8'h44);
        send(8'hA5);
        check("bad_error_clear", load_error, 0);
        send(8'h10); send(8'h01); send(8'h44); send(8'h55);
        check("good_after_bad_done", load_done, 1);

        // Address wrap 0xFE -> 0xFF -> 0x00.
        push_wr(8'hFE, 8'h01); push_wr(8'hFF, 8'h02); push_wr(8'h00, 8'h03);
        send(8'hA5); send(8'hFE); send(8'h03);
        send(8'h01); send(8'h02); send(8'h03); send(8'h07);
        check("wrap_done", load_done, 1);
        check("wrap_q_empty", exp_q.size(), 0);

        // Timeout: exactly TO silent cycles aborts the frame.
        send(8'hA5); send(8'h00); send(8'h00);
        repeat (TO - 1) tick();
        check("to_busy_before", busy, 1);
        check("to_error_before", load_error, 0);
        tick();
        check("to_error", load_error, 1);
        check("to_busy", busy, 0);
        check("to_hold", cpu_hold, 1);

        // A byte arriving on the would-be timeout cycle wins; then length 256.
        send(8'hA5);
        repeat (TO - 1) tick();
        send(8'h00);
        check("race_busy", busy, 1);
        check("race_no_error", load_error, 0);
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            push_wr(i[7:0], 8'h01);
            send(8'h01);
        end
        check("len256_busy", busy, 1);
        send(8'h00);
        check("len256_done", load_done, 1);
        check("len256_q_empty", exp_q.size(), 0);

        // Header value inside data is plain data. Checksum is
        // 0x20+0x02+0xA5+0xA5 = 0x16C -> 0x6C.
        push_wr(8'h20, 8'hA5); push_wr(8'h21, 8'hA5);
        send(8'hA5); send(8'h20); send(8'h02);
        send(8'hA5); send(8'hA5); send(8'h6C);
        check("hdr_data_done", load_done, 1);

        // Mid-frame reset: no further writes.
        push_wr(8'h20, 8'hAA);
        send(8'hA5); send(8'h20); send(8'h04); send(8'hAA);
        reset = 1'b1;
        tick();
        check("mid_rst_hold", cpu_hold, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_write", mem_write, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_error", load_error, 0);
        reset = 1'b0;
        send(8'hBB); send(8'hCC);
        tick();
        tick();
        check("mid_rst_idle", busy, 0);
        check("final_q_empty", exp_q.size(), 0);
        check("done_count", done_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
